// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared constants and state encoding for the 4-lane PHY receive unstriper
package phy_rx_pkg;
  localparam int PHY_LANES = 4;
  localparam int PHY_DATA_W = 8;
  localparam logic [7:0] PHY_COM = 8'hBC;
  typedef enum logic {HUNT, ALIGNED} state_t;
endpackage

// File: rtl/phy_rx_grp_reg.sv
// phy_rx_grp_reg: group holding register with valid/ready handshake and load-while-consume
module phy_rx_grp_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         out_ready,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (load) dout <= din;
      valid <= load | (valid & ~out_ready);
    end
  end
endmodule

// File: rtl/phy_rx_unstripe.sv
// phy_rx_unstripe: COM-aligned byte-to-4-lane unstriper; PHY_RX_ALIGN_ERR_EN adds align_err_cnt
module phy_rx_unstripe
  import phy_rx_pkg::*;
#(
  parameter int DATA_W = PHY_DATA_W,
  parameter int LANES = PHY_LANES,
  parameter logic [DATA_W-1:0] COM = PHY_COM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              valid0,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3,
  input  logic              out_ready,
  output logic              aligned
`ifdef PHY_RX_ALIGN_ERR_EN
  , output logic [7:0]      align_err_cnt
`endif
);
  localparam logic [1:0] LAST = 2'(LANES - 1);
  state_t state, state_n;
  logic [1:0] idx, idx_n, wr_idx;
  logic [DATA_W-1:0] s0, s1, s2;
  logic accept, is_com, wr, complete, valid;
  logic [4*DATA_W-1:0] grp;
  assign in_ready = !(valid && !out_ready && idx == LAST && state == ALIGNED);
  // A COM always restarts the group at slot 0, whether in HUNT or misaligned in ALIGNED
  always_comb begin
    accept   = valid_in && in_ready;
    is_com   = data_in == COM;
    wr       = accept && (state == ALIGNED || is_com);
    wr_idx   = is_com ? 2'd0 : idx;
    idx_n    = wr ? (is_com ? 2'd1 : idx + 2'd1) : idx;
    state_n  = wr ? ALIGNED : state;
    complete = wr && !is_com && idx == LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
      idx   <= 2'd0;
      s0    <= '0;
      s1    <= '0;
      s2    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (wr && wr_idx == 2'd0) s0 <= data_in;
      if (wr && wr_idx == 2'd1) s1 <= data_in;
      if (wr && wr_idx == 2'd2) s2 <= data_in;
    end
  end
  phy_rx_grp_reg #(.W(4 * DATA_W)) u_grp (
    .clk(clk),
    .reset(reset),
    .load(complete),
    .out_ready(out_ready),
    .din({data_in, s2, s1, s0}),
    .dout(grp),
    .valid(valid)
  );
  assign {out3, out2, out1, out0} = grp;
  assign {valid3, valid2, valid1, valid0} = {4{valid}};
  assign aligned = state == ALIGNED;
`ifdef PHY_RX_ALIGN_ERR_EN
  logic misalign;
  assign misalign = wr && is_com && state == ALIGNED && idx != 2'd0;
  always_ff @(posedge clk) begin
    if (reset) align_err_cnt <= 8'h00;
    else if (misalign && align_err_cnt != 8'hFF) align_err_cnt <= align_err_cnt + 8'h01;
  end
`endif
endmodule

// File: tb/tb_phy_rx_unstripe.sv
// tb_phy_rx_unstripe: table-driven directed bench for phy_rx_unstripe
module tb_phy_rx_unstripe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic valid_in = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, aligned, valid0, valid1, valid2, valid3;
  logic [7:0] out0, out1, out2, out3;
  int total = 0;
  int bad = 0;
`ifdef PHY_RX_ALIGN_ERR_EN
  logic [7:0] align_err_cnt;
`endif

  phy_rx_unstripe dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .in_ready(in_ready),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .valid0(valid0),
    .valid1(valid1),
    .valid2(valid2),
    .valid3(valid3),
    .out_ready(out_ready),
    .aligned(aligned)
`ifdef PHY_RX_ALIGN_ERR_EN
    , .align_err_cnt(align_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vi;
    logic [7:0] d;
    logic ordy;
    logic rdy;
    logic vld;
    logic [31:0] grp;
    logic al;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic vi, input logic [7:0] d, input logic ordy, input logic rdy,
                     input logic vld, input logic [31:0] grp, input logic al);
    vec_t v;
    v.vi = vi; v.d = d; v.ordy = ordy; v.rdy = rdy; v.vld = vld; v.grp = grp; v.al = al;
    tv.push_back(v);
  endtask

  task automatic step(input logic vi, input logic [7:0] d, input logic ordy, input logic rdy,
                      input logic vld, input logic [31:0] grp, input logic al);
    @(negedge clk);
    valid_in = vi;
    data_in = d;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    chk("valid", 32'({valid3, valid2, valid1, valid0}), 32'({4{vld}}));
    if (vld) chk("group", {out3, out2, out1, out0}, grp);
    chk("aligned", 32'(aligned), 32'(al));
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", 32'({valid3, valid2, valid1, valid0}), 32'h0);
    chk("rst_out", {out3, out2, out1, out0}, 32'h0);
    chk("rst_aligned", 32'(aligned), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // hunt, first group, exactly one valid cycle
    add(1, 8'h11, 1, 1, 0, 0, 0);
    add(1, 8'h22, 1, 1, 0, 0, 0);
    add(1, 8'hBC, 1, 1, 0, 0, 1);
    add(1, 8'hFF, 1, 1, 0, 0, 1);
    add(1, 8'hEE, 1, 1, 0, 0, 1);
    add(1, 8'hDD, 1, 1, 1, 32'hDDEEFFBC, 1);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    // gaps mid-group, no per-group COM
    add(1, 8'hBB, 1, 1, 0, 0, 1);
    add(1, 8'hAA, 1, 1, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    add(1, 8'h99, 1, 1, 0, 0, 1);
    add(1, 8'h88, 1, 1, 1, 32'h8899AABB, 1);
    // backpressure stalls only the completing byte
    add(1, 8'h01, 0, 1, 1, 32'h8899AABB, 1);
    add(1, 8'h02, 0, 1, 1, 32'h8899AABB, 1);
    add(1, 8'h03, 0, 1, 1, 32'h8899AABB, 1);
    add(1, 8'h04, 0, 0, 1, 32'h8899AABB, 1);
    add(1, 8'h04, 0, 0, 1, 32'h8899AABB, 1);
    add(1, 8'h04, 1, 1, 1, 32'h04030201, 1);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    // misaligned COM at idx 2
    add(1, 8'h10, 1, 1, 0, 0, 1);
    add(1, 8'h20, 1, 1, 0, 0, 1);
    add(1, 8'hBC, 1, 1, 0, 0, 1);
    add(1, 8'h55, 1, 1, 0, 0, 1);
    add(1, 8'h77, 1, 1, 0, 0, 1);
    add(1, 8'h66, 1, 1, 1, 32'h667755BC, 1);
    add(0, 8'h00, 1, 1, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) step(tv[i].vi, tv[i].d, tv[i].ordy, tv[i].rdy, tv[i].vld, tv[i].grp, tv[i].al);
`ifdef PHY_RX_ALIGN_ERR_EN
    chk("align_err_cnt", 32'(align_err_cnt), 32'h1);
`endif

    // reset with a held group and a partial group in flight
    step(1, 8'h31, 0, 1, 0, 0, 1);
    step(1, 8'h32, 0, 1, 0, 0, 1);
    step(1, 8'h33, 0, 1, 0, 0, 1);
    step(1, 8'h34, 0, 1, 1, 32'h34333231, 1);
    step(1, 8'h41, 0, 1, 1, 32'h34333231, 1);
    step(1, 8'h42, 0, 1, 1, 32'h34333231, 1);
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state();
`ifdef PHY_RX_ALIGN_ERR_EN
    chk("rst_err_cnt", 32'(align_err_cnt), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 1, 1, 0, 0, 0);
    step(1, 8'hBC, 1, 1, 0, 0, 1);
    step(1, 8'hA1, 1, 1, 0, 0, 1);
    step(1, 8'hA2, 1, 1, 0, 0, 1);
    step(1, 8'hA3, 1, 1, 1, 32'hA3A2A1BC, 1);

    // back-to-back groups, in_ready never drops
    step(1, 8'hB1, 1, 1, 0, 0, 1);
    step(1, 8'hB2, 1, 1, 0, 0, 1);
    step(1, 8'hB3, 1, 1, 0, 0, 1);
    step(1, 8'hB4, 1, 1, 1, 32'hB4B3B2B1, 1);
    step(1, 8'hC1, 1, 1, 0, 0, 1);
    step(1, 8'hC2, 1, 1, 0, 0, 1);
    step(1, 8'hC3, 1, 1, 0, 0, 1);
    step(1, 8'hC4, 1, 1, 1, 32'hC4C3C2C1, 1);
    step(0, 8'h00, 1, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phy_rx_unstripe.md
Name: phy_rx_unstripe

Overview:
Receive-side counterpart of the 4-lane PHY TX mux. Consumes the serialized 8-bit byte stream and aligns it on a COM symbol. Unstripes the bytes round-robin back into four 8-bit lanes. Presents each complete 4-byte group on registered lane outputs with a valid/ready handshake toward the lane consumers.

Parameters:
- DATA_W, 8, byte width of the stream and of each lane.
- LANES, 4, lanes per group; the implementation supports only 4.
- COM, 8'hBC, alignment symbol; it always lands on lane 0.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  serialized byte stream.
- valid_in  in  1  data_in qualifier.
- in_ready  out  1  stage can accept a byte this cycle.
- out0, out1, out2, out3  out  8 each  lane 0..3 bytes of the current group.
- valid0, valid1, valid2, valid3  out  1 each  lane qualifiers; always equal to each other (group valid).
- out_ready  in  1  consumer accepts the group.
- aligned  out  1  state machine is in ALIGNED.

Behaviour:
- Reset, sampled on clk posedge: state=HUNT, idx=0, out0..3=8'h00, valid0..3=0, aligned=0, in_ready=1. Reset mid-group discards the partial group and any held output group.
- A byte is accepted on a cycle when valid_in && in_ready.
- HUNT state:
  - Accepted bytes other than COM are discarded.
  - An accepted COM is written to assembly slot 0; idx becomes 1; state goes to ALIGNED.
- ALIGNED state:
  - An accepted byte is written to slot[idx]; idx increments modulo 4.
  - Accepting the byte at idx==3 completes the group. On the same edge the output registers load slots 0..2 plus the incoming byte, valid0..3 rise, and idx wraps to 0.
  - Latency: last byte of a group accepted at edge N → group visible after edge N, with no extra cycles.
- Alignment rules:
  - An accepted COM at idx!=0 is a misalignment. The partial group is dropped, the COM goes to slot 0, and idx becomes 1. State stays ALIGNED.
  - An accepted non-COM byte at idx==0 is legal data; no per-group COM is required.
- valid_in=0 holds idx and the slots unchanged (gaps allowed anywhere in a group).
- Output handshake:
  - valid0..3 && out_ready at an edge consumes the group. valid0..3 fall unless a new group completes on the same edge, in which case the new group loads and valid stays 1.
  - While valid0..3 && !out_ready, the outputs hold stable.
- in_ready = !(valid0 && !out_ready && idx==3 && state==ALIGNED). Only the group-completing byte is stalled; bytes at idx 0..2 are always accepted. in_ready is 1 throughout HUNT.
- Exit from ALIGNED only via reset.

Optional Feature:
- Macro PHY_RX_ALIGN_ERR_EN.
- When defined, adds output port align_err_cnt, 8 bits. It increments on each misalignment event (COM at idx!=0 in ALIGNED), saturates at 8'hFF, and resets to 0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package phy_rx_pkg holds:
  - constants PHY_LANES=4, PHY_DATA_W=8, PHY_COM=8'hBC;
  - state typedef {HUNT, ALIGNED} with a 1-bit encoding.
- Sub-module phy_rx_grp_reg is the natural split: a 32-bit output holding register with the valid/ready handshake and load-while-consume logic. The top level keeps the state machine, idx counter and assembly slots.

Test Plan:
- Reset, then stream 11,22,BC,FF,EE,DD with out_ready=1 → 11 and 22 dropped; aligned=1 after BC; after DD, out0..3=BC,FF,EE,DD and valid0..3=1 for exactly 1 cycle.
- Aligned; stream BB,AA,99,88 with valid_in low for 2 cycles between AA and 99 → one group BB,AA,99,88; valid asserted only after 88 is accepted.
- Group held with out_ready=0; send 3 bytes, then a 4th → first 3 accepted; in_ready=0 on the 4th and outputs stable; raise out_ready → 4th accepted, new group loads with valid continuous.
- Aligned at idx=2; send BC,55,77,66 → partial group dropped; output 55→lane1, group BC,55,77,66; align_err_cnt=1 when PHY_RX_ALIGN_ERR_EN is defined.
- Assert reset after 2 bytes of a group and with a held output → valid0..3=0, out0..3=00, aligned=0; a following non-COM stream produces no output until COM arrives.
- Back-to-back groups with out_ready=1 continuously (8 bytes on 8 consecutive cycles) → two groups on cycles 4 and 8; no in_ready deassertion.
